// File: rtl/algo_sequencer.sv
// Cycle-exact sequencer: sample accept -> settle window -> capture algo decision -> order handshake.
// Optional macro ALGO_SEQ_DEDUP_EN suppresses repeat orders in the same direction as the last one issued.
module algo_sequencer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] algo_in,
  input  logic              algo_out1,
  input  logic              algo_out2,
  output logic              ord_valid,
  input  logic              ord_ready,
  output logic              ord_buy,
  output logic              ord_sell,
  output logic [CNT_W-1:0]  ord_seq,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  order_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, EVAL, ISSUE} state_t;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;
  logic       accept, hs, dec_one, dec_both, suppress, issue_go;

  assign s_ready  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = s_valid & s_ready;
  assign hs       = ord_valid & ord_ready;
  assign dec_one  = algo_out1 ^ algo_out2;
  assign dec_both = algo_out1 & algo_out2;

`ifdef ALGO_SEQ_DEDUP_EN
  typedef enum logic [1:0] {DIR_NONE, DIR_BUY, DIR_SELL} dir_t;
  dir_t last_dir;

  // Direction memory advances only when an order actually leaves the block.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_dir <= DIR_NONE;
    else if (state == ISSUE && hs)
      last_dir <= ord_buy ? DIR_BUY : DIR_SELL;
  end

  assign suppress = dec_one && ((algo_out1 && last_dir == DIR_BUY) ||
                                (algo_out2 && last_dir == DIR_SELL));
`else
  assign suppress = 1'b0;
`endif

  assign issue_go = dec_one & ~suppress;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = SETTLE;
      SETTLE: if (settle_cnt == 8'd0) state_nxt = EVAL;
      EVAL:   state_nxt = issue_go ? ISSUE : IDLE;
      ISSUE:  if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      algo_in      <= '0;
      settle_cnt   <= '0;
      ord_valid    <= 1'b0;
      ord_buy      <= 1'b0;
      ord_sell     <= 1'b0;
      ord_seq      <= '0;
      sample_cnt   <= '0;
      order_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (accept) begin
        algo_in    <= s_data;
        sample_cnt <= sample_cnt + 1'b1;
        settle_cnt <= 8'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE && settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;
      if (state == EVAL) begin
        if (issue_go) begin
          ord_valid <= 1'b1;
          ord_buy   <= algo_out1;
          ord_sell  <= algo_out2;
          ord_seq   <= order_cnt;
        end
        if (dec_both)
          conflict_cnt <= conflict_cnt + 1'b1;
      end
      // Direction flags clear with valid so they never linger on an idle port.
      if (state == ISSUE && hs) begin
        ord_valid <= 1'b0;
        ord_buy   <= 1'b0;
        ord_sell  <= 1'b0;
        order_cnt <= order_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_algo_sequencer.sv
// Directed bench for algo_sequencer: algo is stubbed by bench-driven out1/out2.
module tb_algo_sequencer;
  localparam int DATA_W = 32;
  localparam int SC     = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready;
  logic [DATA_W-1:0] s_data, algo_in;
  logic              algo_out1, algo_out2;
  logic              ord_valid, ord_ready, ord_buy, ord_sell, busy;
  logic [CNT_W-1:0]  ord_seq, sample_cnt, order_cnt, conflict_cnt;

  int n_chk = 0;
  int n_err = 0;

  algo_sequencer #(.DATA_W(DATA_W), .SETTLE_CYCLES(SC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .algo_in(algo_in), .algo_out1(algo_out1), .algo_out2(algo_out2),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_buy(ord_buy), .ord_sell(ord_sell),
    .ord_seq(ord_seq), .busy(busy),
    .sample_cnt(sample_cnt), .order_cnt(order_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s_ready"},   32'(s_ready), 32'd1);
    chk({tag, ".ord_valid"}, 32'(ord_valid), 32'd0);
    chk({tag, ".ord_buy"},   32'(ord_buy), 32'd0);
    chk({tag, ".ord_sell"},  32'(ord_sell), 32'd0);
    chk({tag, ".ord_seq"},   32'(ord_seq), 32'd0);
    chk({tag, ".algo_in"},   algo_in, 32'd0);
    chk({tag, ".sample_cnt"},   32'(sample_cnt), 32'd0);
    chk({tag, ".order_cnt"},    32'(order_cnt), 32'd0);
    chk({tag, ".conflict_cnt"}, 32'(conflict_cnt), 32'd0);
    chk({tag, ".busy"},      32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    chk_reset("reset");
    rst_n = 1'b1;
  endtask

  // Presents one sample while IDLE; it is taken on the next edge.
  task automatic accept(input logic [31:0] d, input logic o1, input logic o2);
    s_data = d; s_valid = 1'b1; algo_out1 = o1; algo_out2 = o2;
    tick(1);
    s_valid = 1'b0;
    chk("algo_in", algo_in, d);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Full transaction: accept, settle, evaluate, optional order handshake.
  task automatic run(input logic [31:0] d, input logic o1, input logic o2,
                     input logic exp_ord, input logic exp_buy, input int exp_seq);
    accept(d, o1, o2);
    tick(SC);
    chk("eval_no_valid", 32'(ord_valid), 32'd0);
    chk("eval_s_ready", 32'(s_ready), 32'd0);
    tick(1);
    chk("ord_valid", 32'(ord_valid), 32'(exp_ord));
    if (exp_ord) begin
      chk("ord_buy", 32'(ord_buy), 32'(exp_buy));
      chk("ord_sell", 32'(ord_sell), 32'(!exp_buy));
      chk("ord_seq", 32'(ord_seq), 32'(exp_seq));
      ord_ready = 1'b1;
      tick(1);
      ord_ready = 1'b0;
      chk("hs_valid_low", 32'(ord_valid), 32'd0);
    end
    chk("back_idle", 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic o1;
    int   exp_orders;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    algo_out1 = 1'b0; algo_out2 = 1'b0; ord_ready = 1'b0;
    tick(2);
    chk_reset("reset_init");
    rst_n = 1'b1;

    // Buy path
    run(32'h1E, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    chk("t1_order_cnt", 32'(order_cnt), 32'd1);
    chk("t1_sample_cnt", 32'(sample_cnt), 32'd1);

    // No decision, then conflict
    run(32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run(32'h33, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("t2_conflict_cnt", 32'(conflict_cnt), 32'd1);
    chk("t2_order_cnt", 32'(order_cnt), 32'd1);

    // Backpressure on a sell order
    accept(32'h44, 1'b0, 1'b1);
    tick(SC + 1);
    chk("t3_valid", 32'(ord_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      s_valid = i[0];
      s_data  = 32'hDEAD;
      tick(1);
      chk("t3_hold_valid", 32'(ord_valid), 32'd1);
      chk("t3_hold_sell", 32'(ord_sell), 32'd1);
      chk("t3_hold_buy", 32'(ord_buy), 32'd0);
      chk("t3_hold_seq", 32'(ord_seq), 32'd1);
      chk("t3_s_ready", 32'(s_ready), 32'd0);
      chk("t3_sample_cnt", 32'(sample_cnt), 32'd4);
    end
    s_valid = 1'b0;
    chk("t3_algo_in", algo_in, 32'h44);
    ord_ready = 1'b1;
    tick(1);
    ord_ready = 1'b0;
    chk("t3_order_cnt", 32'(order_cnt), 32'd2);
    chk("t3_valid_low", 32'(ord_valid), 32'd0);

    // Reset during SETTLE, then during ISSUE
    do_reset();
    accept(32'h55, 1'b1, 1'b0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk_reset("rst_settle");
    rst_n = 1'b1;
    accept(32'h66, 1'b1, 1'b0);
    tick(SC + 1);
    chk("t4_valid", 32'(ord_valid), 32'd1);
    ord_ready = 1'b1;
    rst_n = 1'b0;
    tick(1);
    ord_ready = 1'b0;
    chk_reset("rst_issue");
    rst_n = 1'b1;
    tick(2);
    chk("t4_no_replay", 32'(ord_valid), 32'd0);

    // Counter wrap with 4-bit counters: 17 orders
    do_reset();
    for (int i = 0; i < 17; i++) begin
`ifdef ALGO_SEQ_DEDUP_EN
      o1 = !i[0];
`else
      o1 = 1'b1;
`endif
      run(32'(i + 100), o1, !o1, 1'b1, o1, i % 16);
      if (i == 15) chk("t5_wrap_cnt", 32'(order_cnt), 32'd0);
    end
    chk("t5_order_cnt", 32'(order_cnt), 32'd1);

    // Buy, buy, sell
    do_reset();
    run(32'h70, 1'b1, 1'b0, 1'b1, 1'b1, 0);
`ifdef ALGO_SEQ_DEDUP_EN
    run(32'h71, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run(32'h72, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    exp_orders = 2;
`else
    run(32'h71, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    run(32'h72, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    exp_orders = 3;
`endif
    chk("t6_order_cnt", 32'(order_cnt), 32'(exp_orders));
    chk("t6_sample_cnt", 32'(sample_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
